// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe - instruction decode stage with IR, branch resolution and registered EX control bundle
module decode_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [4+4*RA_W-1:0]   instr,
    output logic                  id_ready,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic [RA_W-1:0]       rf_addr1,
    output logic [RA_W-1:0]       rf_addr2,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [DATA_W-1:0]     rf_data2,
    output logic [RA_W-1:0]       hz_src1,
    output logic [RA_W-1:0]       hz_src2,
    output logic                  br_taken,
    output logic [2*RA_W-1:0]     br_offset,
    output logic                  ex_valid,
    output logic [2:0]            ex_alu_cmd,
    output logic [DATA_W-1:0]     ex_src1,
    output logic [DATA_W-1:0]     ex_src2,
    output logic                  ex_mem_we,
    output logic [DATA_W-1:0]     ex_mem_wdata,
    output logic                  ex_wb_en,
    output logic [RA_W-1:0]       ex_wb_dest,
    output logic                  ex_wb_sel,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int INSTR_W = 4 + 4*RA_W;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SRU  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_cmd;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic              mem_we;
        logic [DATA_W-1:0] mem_wdata;
        logic              wb_en;
        logic [RA_W-1:0]   wb_dest;
        logic              wb_sel;
    } ex_bundle_t;

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    ex_bundle_t         ex_q, ex_d, dec;
    logic               illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

    logic [3:0]         op;
    logic [RA_W-1:0]    f_dest, f_src1, f_src2;
    logic [2*RA_W-1:0]  f_imm;
    logic [DATA_W-1:0]  imm_sext;
    logic               is_illegal, uses_src1, uses_src2, is_st;
    logic               br_cond, issue;

    assign op       = ir_q[INSTR_W-1 -: 4];
    assign f_dest   = ir_q[4*RA_W-1 -: RA_W];
    assign f_src1   = ir_q[3*RA_W-1 -: RA_W];
    assign f_src2   = ir_q[2*RA_W-1 -: RA_W];
    assign f_imm    = ir_q[2*RA_W-1:0];
    assign imm_sext = {{(DATA_W-2*RA_W){f_imm[2*RA_W-1]}}, f_imm};

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        is_illegal = 1'b0;
        uses_src1  = 1'b0;
        uses_src2  = 1'b0;
        is_st      = 1'b0;
        if (op == OP_NOP) begin
            dec.valid = 1'b1;
        end else if (op <= OP_SRU) begin
            dec.alu_cmd = 3'(op - 4'd1);
            dec.src1    = rf_data1;
            dec.src2    = rf_data2;
            dec.wb_en   = 1'b1;
            dec.wb_dest = f_dest;
            uses_src1   = 1'b1;
            uses_src2   = 1'b1;
        end else if (op == OP_ADDI || op == OP_LD) begin
            dec.src1    = rf_data1;
            dec.src2    = imm_sext;
            dec.wb_en   = 1'b1;
            dec.wb_dest = f_dest;
            dec.wb_sel  = (op == OP_LD);
            uses_src1   = 1'b1;
        end else if (op == OP_ST) begin
            // Store data register lives in the dest field.
            dec.src1      = rf_data1;
            dec.src2      = imm_sext;
            dec.mem_we    = 1'b1;
            dec.mem_wdata = rf_data2;
            uses_src1     = 1'b1;
            uses_src2     = 1'b1;
            is_st         = 1'b1;
        end else if (op == OP_BR) begin
            dec.src1  = rf_data1;
            uses_src1 = 1'b1;
        end else begin
            is_illegal = 1'b1;
        end
    end

    always_comb begin
        br_cond = 1'b0;
        if (f_dest == RA_W'(0))
            br_cond = (rf_data1 == '0);
        else if (f_dest == RA_W'(1))
            br_cond = (rf_data1 != '0);
        else if (f_dest == RA_W'(2))
            br_cond = ($signed(rf_data1) > $signed({DATA_W{1'b0}}));
        else if (f_dest == RA_W'(3))
            br_cond = ($signed(rf_data1) <= $signed({DATA_W{1'b0}}));
    end

    assign id_ready  = ex_ready & ~stall;
    assign issue     = ir_valid_q & ~stall & ex_ready;
    assign br_taken  = issue & (op == OP_BR) & br_cond;
    assign br_offset = f_imm;
    assign rf_addr1  = f_src1;
    assign rf_addr2  = is_st ? f_dest : f_src2;
    assign hz_src1   = (ir_valid_q & uses_src1) ? f_src1 : '0;
    assign hz_src2   = (ir_valid_q & uses_src2) ? rf_addr2 : '0;

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            ir_valid_d = 1'b0;
        end else if (!id_ready) begin
            ir_valid_d = ir_valid_q;
        end else if (br_taken) begin
            ir_valid_d = 1'b0;
        end else begin
            ir_d       = instr;
            ir_valid_d = if_valid;
        end
    end

    always_comb begin
        ex_d         = ex_q;
        illegal_op_d = ~flush & issue & is_illegal;
        bubble_cnt_d = bubble_cnt_q;
        if (flush)
            ex_d = '0;
        else if (!ex_ready)
            ex_d = ex_q;
        else if (stall || !ir_valid_q || is_illegal)
            ex_d = '0;
        else
            ex_d = dec;
        if (stall && ir_valid_q && ex_ready && !flush && bubble_cnt_q != {CNT_W{1'b1}})
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            ex_q         <= '0;
            illegal_op_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            ex_q         <= ex_d;
            illegal_op_q <= illegal_op_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_cmd   = ex_q.alu_cmd;
    assign ex_src1      = ex_q.src1;
    assign ex_src2      = ex_q.src2;
    assign ex_mem_we    = ex_q.mem_we;
    assign ex_mem_wdata = ex_q.mem_wdata;
    assign ex_wb_en     = ex_q.wb_en;
    assign ex_wb_dest   = ex_q.wb_dest;
    assign ex_wb_sel    = ex_q.wb_sel;
    assign illegal_op   = illegal_op_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed self-checking bench for decode_stage_pipe
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] instr;
    logic        id_ready;
    logic        stall, flush, ex_ready;
    logic [2:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic [2:0]  hz_src1, hz_src2;
    logic        br_taken;
    logic [5:0]  br_offset;
    logic        ex_valid;
    logic [2:0]  ex_alu_cmd;
    logic [15:0] ex_src1, ex_src2;
    logic        ex_mem_we;
    logic [15:0] ex_mem_wdata;
    logic        ex_wb_en;
    logic [2:0]  ex_wb_dest;
    logic        ex_wb_sel;
    logic        illegal_op;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] I_ADDI = 16'h923F; // ADDI r1,r0,-1
    localparam logic [15:0] I_ADD  = 16'h1448; // ADD  r2,r1,r1
    localparam logic [15:0] I_SUB  = 16'h2650; // SUB  r3,r1,r2
    localparam logic [15:0] I_BR   = 16'hC444; // BR   cond=2 on r1, off=4
    localparam logic [15:0] I_ST   = 16'hB645; // ST   r3,[r1+5]
    localparam logic [15:0] I_ILL  = 16'hE000;

    decode_stage_pipe #(.DATA_W(16), .RA_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .id_ready(id_ready),
        .stall(stall), .flush(flush), .ex_ready(ex_ready),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .hz_src1(hz_src1), .hz_src2(hz_src2), .br_taken(br_taken), .br_offset(br_offset),
        .ex_valid(ex_valid), .ex_alu_cmd(ex_alu_cmd), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_mem_we(ex_mem_we), .ex_mem_wdata(ex_mem_wdata), .ex_wb_en(ex_wb_en),
        .ex_wb_dest(ex_wb_dest), .ex_wb_sel(ex_wb_sel), .illegal_op(illegal_op),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        rf_data1 = 16'hFFFF; rf_data2 = 16'hFFFF;
        #12 rst = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_id_ready", id_ready, 1);

        // ADDI then ADD
        if_valid = 1'b1; instr = I_ADDI;
        tick();
        chk("addi_hz_src2", hz_src2, 0);
        instr = I_ADD;
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_src1", ex_src1, 16'hFFFF);
        chk("addi_src2", ex_src2, 16'hFFFF);
        chk("addi_dest", ex_wb_dest, 1);
        chk("addi_wb_en", ex_wb_en, 1);
        chk("add_rf_addr2", rf_addr2, 1);
        chk("add_hz_src2", hz_src2, 1);
        if_valid = 1'b0;
        tick();
        chk("add_alu", ex_alu_cmd, 0);
        chk("add_dest", ex_wb_dest, 2);
        chk("add_valid", ex_valid, 1);
        tick();
        chk("idle_bubble", ex_valid, 0);

        // stall two cycles with SUB held in IR
        if_valid = 1'b1; instr = I_SUB;
        tick();
        stall = 1'b1; instr = I_ADD;
        #1 chk("stall_id_ready", id_ready, 0);
        tick();
        chk("stall1_valid", ex_valid, 0);
        chk("stall1_cnt", bubble_cnt, 1);
        tick();
        chk("stall2_valid", ex_valid, 0);
        chk("stall2_wb_en", ex_wb_en, 0);
        chk("stall2_cnt", bubble_cnt, 2);
        chk("stall2_ir_held", hz_src2, 2);
        stall = 1'b0; if_valid = 1'b0;
        tick();
        chk("sub_valid", ex_valid, 1);
        chk("sub_alu", ex_alu_cmd, 1);
        chk("sub_dest", ex_wb_dest, 3);

        // ex_ready low for three cycles holding ADD bundle, SUB in IR
        if_valid = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        chk("pre_hold_dest", ex_wb_dest, 2);
        ex_ready = 1'b0; instr = I_ADDI;
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            #1 chk("hold_id_ready", id_ready, 0);
            tick();
            chk("hold_valid", ex_valid, 1);
            chk("hold_dest", ex_wb_dest, 2);
            chk("hold_ir", hz_src2, 2);
            chk("hold_cnt", bubble_cnt, 2);
        end
        ex_ready = 1'b1; stall = 1'b0; if_valid = 1'b0;
        tick();
        chk("resume_dest", ex_wb_dest, 3);
        chk("resume_alu", ex_alu_cmd, 1);

        // branch on r1 > 0
        if_valid = 1'b1; instr = I_BR;
        tick();
        instr = I_ADD;
        rf_data1 = 16'h8000;
        #1 chk("br_neg_not_taken", br_taken, 0);
        chk("br_offset", br_offset, 4);
        rf_data1 = 16'h0001;
        #1 chk("br_pos_taken", br_taken, 1);
        tick();
        chk("br_valid", ex_valid, 1);
        chk("br_wb_en", ex_wb_en, 0);
        chk("br_mem_we", ex_mem_we, 0);
        chk("br_squash_hz", hz_src1, 0);
        if_valid = 1'b0;
        tick();
        chk("br_squash_bubble", ex_valid, 0);

        // store, then illegal opcode
        if_valid = 1'b1; instr = I_ST;
        tick();
        chk("st_rf_addr2", rf_addr2, 3);
        chk("st_hz_src2", hz_src2, 3);
        rf_data1 = 16'h0010; rf_data2 = 16'h1234; instr = I_ILL;
        tick();
        chk("st_mem_we", ex_mem_we, 1);
        chk("st_src1", ex_src1, 16'h0010);
        chk("st_src2", ex_src2, 16'h0005);
        chk("st_wdata", ex_mem_wdata, 16'h1234);
        chk("st_wb_en", ex_wb_en, 0);
        chk("st_illegal_low", illegal_op, 0);
        if_valid = 1'b0;
        tick();
        chk("ill_pulse", illegal_op, 1);
        chk("ill_bubble", ex_valid, 0);
        tick();
        chk("ill_pulse_end", illegal_op, 0);

        // flush with stall and ex_ready low
        if_valid = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        chk("pre_flush_valid", ex_valid, 1);
        flush = 1'b1; stall = 1'b1; ex_ready = 1'b0;
        tick();
        chk("flush_valid", ex_valid, 0);
        chk("flush_wb_dest", ex_wb_dest, 0);
        chk("flush_cnt", bubble_cnt, 2);
        flush = 1'b0; stall = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
        tick();
        chk("flush_ir_invalid", ex_valid, 0);

        // async reset mid-stream
        if_valid = 1'b1; instr = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_cnt", bubble_cnt, 0);
        chk("arst_hz", hz_src1, 0);
        #2 rst = 1'b0; if_valid = 1'b0;
        tick();
        chk("post_rst_bubble", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
